seq_alu_muldiv: RTL and testbench
=================================

Name: seq_alu_muldiv

Overview:
- Parametrised, clocked successor to the team's combinational ALU.
- Keeps the seven basic ops: add, sub, shl, shr, eq, gt, lt.
- Adds a multi-cycle unsigned shift-add multiply and a restoring divide.
- Uses a start/busy/done handshake and registered results and flags, so it can sit directly on the datapath register boundary.

Parameters:
- size, 8: operand and result width in bits; legal values are size >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset; single clock domain
- start  input  1  request; sampled only while busy=0
- a  input  size  operand A; unsigned
- b  input  size  operand B; unsigned
- op  input  4  operation code
- out  output  size  result; for mul, the low half; for div, the quotient
- out_hi  output  size  mul high half; div remainder; 0 for all other ops
- of  output  1  add carry-out; for mul, set when out_hi != 0
- un  output  1  sub borrow (a < b)
- err  output  1  invalid op or divide by zero
- zero  output  1  {out_hi,out}==0 for every valid op
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse when results update

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - out, out_hi, of, un, err, zero, busy and done all 0.
  - Internal accumulators are cleared.
  - Reset mid-operation aborts the op with no done pulse.
- Op codes:
  - 0000 add, 0001 sub, 0010 a<<b, 0011 a>>b, 0100 a==b, 0101 a>b, 0110 a<b, 0111 mul, 1000 div.
  - 1001-1111 are invalid.
- Shifts: shift amount is the full b; if b >= size, out=0.
- Compares: out is 0 or 1, zero-extended.
- Flags:
  - All flags are recomputed on every accepted op; flags not defined for that op are 0.
  - Flags and results are held until the next done.
- States: IDLE, MUL, DIV.
- IDLE behaviour: start=1 on edge N latches a, b and op.
  - Single-cycle ops and invalid ops register their result, flags and done=1 on edge N (latency 1), then stay in IDLE.
  - Invalid op: err=1, out=0, out_hi=0, zero=0.
  - div with b==0: err=1, out={size{1'b1}}, out_hi=a, zero=0, done on edge N, no iterations.
  - Valid mul: edge N sets busy=1 and loads the accumulator, then state goes to MUL.
  - Valid div: same as mul, but state goes to DIV.
- MUL: one shift-add step per cycle, LSB first, on edges N+1..N+size.
  - On edge N+size: {out_hi,out}=a*b (2*size bits, exact), of=(out_hi!=0), zero set per the zero rule, busy=0, done=1, state goes to IDLE.
- DIV: one restoring step per cycle, MSB first, on edges N+1..N+size.
  - On edge N+size: out=a/b, out_hi=a%b, busy=0, done=1, state goes to IDLE.
- Handshake:
  - start is ignored while busy=1; there is no queueing and latched operands are not disturbed.
  - done is high for exactly one cycle per accepted op.
  - A start in the same cycle that done is asserted is accepted, because busy is already 0.
- Outputs are not updated while busy=1; they hold the previous op's values until done.

Test Plan:
- size=8, add a=200 b=100 -> edge after start: out=44, of=1, un=0, zero=0, done=1 for one cycle, busy stays 0.
- sub a=5 b=7 -> out=254, un=1, zero=0; then sub a=9 b=9 -> out=0, un=0, zero=1; then shl a=1 b=9 -> out=0, zero=1.
- mul a=200 b=3 -> busy=1 for 8 cycles; done exactly 8 edges after the start edge with out=0x58, out_hi=0x02, of=1; mul a=0 b=77 -> zero=1, of=0.
- div a=200 b=7 -> after 8 edges: out=28, out_hi=4, err=0; div a=200 b=0 -> next edge: err=1, out=0xFF, out_hi=200, done=1, busy never set.
- start pulsed with add at cycle 3 of an active mul -> ignored, mul result unchanged; rst_n=0 at cycle 4 of a mul -> busy=0, done=0, out=0 immediately (asynchronous), and no done after release.
- op=4'b1111 a=3 b=4 -> err=1, out=0, zero=0, done=1; back-to-back start on the done cycle (add 1+1) -> accepted, out=2 on the next edge.

Source files
------------

// File: rtl/seq_alu_muldiv_if.sv
// Handshake and operand/result bundle for the sequential ALU.
interface seq_alu_muldiv_if #(
  parameter int size = 8
);
  logic            start;
  logic [size-1:0] a;
  logic [size-1:0] b;
  logic [3:0]      op;
  logic [size-1:0] out;
  logic [size-1:0] out_hi;
  logic            of;
  logic            un;
  logic            err;
  logic            zero;
  logic            busy;
  logic            done;

  modport master (
    output start, a, b, op,
    input  out, out_hi, of, un, err, zero, busy, done
  );

  modport slave (
    input  start, a, b, op,
    output out, out_hi, of, un, err, zero, busy, done
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Sequential ALU: single-cycle add/sub/shift/compare plus multi-cycle
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module seq_alu_muldiv #(
  parameter int size = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_alu_muldiv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam int              CW   = $clog2(size);
  localparam logic [CW-1:0]   LAST = CW'(size - 1);
  localparam logic [size:0]   SZ   = (size + 1)'(size);

  state_t            state, state_nxt;
  logic [2*size-1:0] acc;
  logic [size-1:0]   opnd;
  logic [CW-1:0]     cnt;
  logic [2*size-1:0] mul_nxt, div_nxt;
  logic [size:0]     add_sum;

  logic [size-1:0]   imm_lo, imm_hi;
  logic              imm_of, imm_un, imm_err, imm_zero, launch;

  // One multiply step: conditionally add multiplicand to upper half, shift right.
  function automatic logic [2*size-1:0] mul_step(input logic [2*size-1:0] p,
                                                 input logic [size-1:0]   m);
    logic [size:0] sum;
    sum = {1'b0, p[2*size-1:size]} + (p[0] ? {1'b0, m} : '0);
    return {sum, p[size-1:1]};
  endfunction

  // One restoring divide step: upper half is the partial remainder, lower
  // half shifts dividend bits out and quotient bits in.
  function automatic logic [2*size-1:0] div_step(input logic [2*size-1:0] rq,
                                                 input logic [size-1:0]   d);
    logic [size:0]   sh;
    logic [size-1:0] diff;
    sh   = {rq[2*size-1:size], rq[size-1]};
    diff = sh[size-1:0] - d;
    if (sh >= {1'b0, d}) return {diff, rq[size-2:0], 1'b1};
    else                 return {sh[size-1:0], rq[size-2:0], 1'b0};
  endfunction

  assign mul_nxt = mul_step(acc, opnd);
  assign div_nxt = div_step(acc, opnd);
  assign add_sum = {1'b0, bus.a} + {1'b0, bus.b};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: launch into MUL/DIV from IDLE, return after the last step.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start && launch) state_nxt = (bus.op == 4'd7) ? MUL : DIV;
      MUL,
      DIV:     if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle results and flags; launch marks ops that need iterations.
  always_comb begin
    imm_lo  = '0;
    imm_hi  = '0;
    imm_of  = 1'b0;
    imm_un  = 1'b0;
    imm_err = 1'b0;
    launch  = 1'b0;
    case (bus.op)
      4'd0: begin imm_lo = add_sum[size-1:0]; imm_of = add_sum[size]; end
      4'd1: begin imm_lo = bus.a - bus.b; imm_un = (bus.a < bus.b); end
      4'd2: imm_lo = ({1'b0, bus.b} >= SZ) ? '0 : (bus.a << bus.b);
      4'd3: imm_lo = ({1'b0, bus.b} >= SZ) ? '0 : (bus.a >> bus.b);
      4'd4: imm_lo = {{(size-1){1'b0}}, bus.a == bus.b};
      4'd5: imm_lo = {{(size-1){1'b0}}, bus.a >  bus.b};
      4'd6: imm_lo = {{(size-1){1'b0}}, bus.a <  bus.b};
      4'd7: launch = 1'b1;
      4'd8: begin
        if (bus.b == '0) begin
          imm_err = 1'b1;
          imm_lo  = '1;
          imm_hi  = bus.a;
        end else begin
          launch = 1'b1;
        end
      end
      default: imm_err = 1'b1;
    endcase
    imm_zero = ~imm_err & ~|{imm_hi, imm_lo};
  end

  // Datapath: operand latch, iteration accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      opnd       <= '0;
      cnt        <= '0;
      bus.out    <= '0;
      bus.out_hi <= '0;
      bus.of     <= 1'b0;
      bus.un     <= 1'b0;
      bus.err    <= 1'b0;
      bus.zero   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (launch) begin
              bus.busy <= 1'b1;
              cnt      <= '0;
              if (bus.op == 4'd7) begin
                acc  <= {{size{1'b0}}, bus.b};
                opnd <= bus.a;
              end else begin
                acc  <= {{size{1'b0}}, bus.a};
                opnd <= bus.b;
              end
            end else begin
              bus.out    <= imm_lo;
              bus.out_hi <= imm_hi;
              bus.of     <= imm_of;
              bus.un     <= imm_un;
              bus.err    <= imm_err;
              bus.zero   <= imm_zero;
              bus.done   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.out    <= mul_nxt[size-1:0];
            bus.out_hi <= mul_nxt[2*size-1:size];
            bus.of     <= |mul_nxt[2*size-1:size];
            bus.un     <= 1'b0;
            bus.err    <= 1'b0;
            bus.zero   <= ~|mul_nxt;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
          end
        end
        DIV: begin
          acc <= div_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.out    <= div_nxt[size-1:0];
            bus.out_hi <= div_nxt[2*size-1:size];
            bus.of     <= 1'b0;
            bus.un     <= 1'b0;
            bus.err    <= 1'b0;
            bus.zero   <= ~|div_nxt;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_muldiv.sv
// Directed-vector bench for seq_alu_muldiv at size=8.
module tb_seq_alu_muldiv;

  logic clk;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;
  int   n;

  seq_alu_muldiv_if #(.size(8)) bus ();

  seq_alu_muldiv #(.size(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one request for a single edge; returns #1 after that edge.
  task automatic start_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done, bounded.
  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!bus.done && cnt < 40);
    if (!bus.done) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.a     = 8'd0;
    bus.b     = 8'd0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",  bus.out,    0);
    check("rst_hi",   bus.out_hi, 0);
    check("rst_busy", bus.busy,   0);
    check("rst_done", bus.done,   0);
    check("rst_zero", bus.zero,   0);
    @(negedge clk);
    rst_n = 1'b1;

    start_op(4'd0, 8'd200, 8'd100);
    check("add_out",  bus.out,  44);
    check("add_of",   bus.of,   1);
    check("add_un",   bus.un,   0);
    check("add_zero", bus.zero, 0);
    check("add_done", bus.done, 1);
    check("add_busy", bus.busy, 0);
    @(posedge clk); #1;
    check("add_done_pulse", bus.done, 0);
    check("add_hold", bus.out, 44);

    start_op(4'd1, 8'd5, 8'd7);
    check("sub_out",  bus.out,  254);
    check("sub_un",   bus.un,   1);
    check("sub_zero", bus.zero, 0);
    start_op(4'd1, 8'd9, 8'd9);
    check("sub0_out",  bus.out,  0);
    check("sub0_un",   bus.un,   0);
    check("sub0_zero", bus.zero, 1);
    start_op(4'd2, 8'd1, 8'd9);
    check("shl_big_out",  bus.out,  0);
    check("shl_big_zero", bus.zero, 1);
    start_op(4'd3, 8'h80, 8'd3);
    check("shr_out", bus.out, 16);
    start_op(4'd5, 8'd5, 8'd3);
    check("gt_out", bus.out, 1);
    start_op(4'd4, 8'd4, 8'd5);
    check("eq_out",  bus.out,  0);
    check("eq_zero", bus.zero, 1);

    start_op(4'd7, 8'd200, 8'd3);
    check("mul_busy", bus.busy, 1);
    check("mul_hold", bus.out,  0);
    wait_done(n);
    check("mul_lat", n, 8);
    check("mul_lo", bus.out,    8'h58);
    check("mul_hi", bus.out_hi, 8'h02);
    check("mul_of", bus.of,     1);
    check("mul_busy_end", bus.busy, 0);
    start_op(4'd7, 8'd0, 8'd77);
    wait_done(n);
    check("mul0_zero", bus.zero, 1);
    check("mul0_of",   bus.of,   0);
    start_op(4'd7, 8'd255, 8'd255);
    wait_done(n);
    check("mulmax_lo", bus.out,    8'h01);
    check("mulmax_hi", bus.out_hi, 8'hFE);

    start_op(4'd8, 8'd200, 8'd7);
    wait_done(n);
    check("div_lat", n, 8);
    check("div_q",   bus.out,    28);
    check("div_r",   bus.out_hi, 4);
    check("div_err", bus.err,    0);
    start_op(4'd8, 8'd200, 8'd0);
    check("div0_err",  bus.err,    1);
    check("div0_out",  bus.out,    8'hFF);
    check("div0_hi",   bus.out_hi, 200);
    check("div0_done", bus.done,   1);
    check("div0_busy", bus.busy,   0);
    check("div0_zero", bus.zero,   0);

    start_op(4'd7, 8'd13, 8'd11);
    repeat (2) @(posedge clk);
    start_op(4'd0, 8'd1, 8'd1);
    check("ign_busy", bus.busy, 1);
    check("ign_hold", bus.out,  8'hFF);
    wait_done(n);
    check("ign_lat", 3 + n, 8);
    check("ign_lo",  bus.out,    143);
    check("ign_hi",  bus.out_hi, 0);
    check("ign_err", bus.err,    0);
    @(posedge clk); #1;
    check("ign_noq_done", bus.done, 0);
    check("ign_noq_out",  bus.out,  143);

    start_op(4'd7, 8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_out",  bus.out,  0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done) n++;
    end
    check("arst_nodone", n, 0);

    start_op(4'd15, 8'd3, 8'd4);
    check("inv_err",  bus.err,  1);
    check("inv_out",  bus.out,  0);
    check("inv_zero", bus.zero, 0);
    check("inv_done", bus.done, 1);
    start_op(4'd0, 8'd1, 8'd1);
    check("b2b_inv_out", bus.out, 2);
    check("b2b_inv_err", bus.err, 0);

    start_op(4'd7, 8'd2, 8'd3);
    wait_done(n);
    check("b2b_mul_out", bus.out, 6);
    start_op(4'd0, 8'd1, 8'd1);
    check("b2b_add_out",  bus.out,  2);
    check("b2b_add_done", bus.done, 1);
    check("b2b_add_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
